// File: rtl/ram_dp_param_if.sv
// User-side bus of ram_dp_param: write/read request signals plus read data and status.
// The master drives the address/data side; the RAM (slave) drives read data and flags.
interface ram_dp_param_if #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 6
);
    logic                 WE;
    logic [ADDR_BITS-1:0] A;
    logic [WIDTH-1:0]     D;
    logic [ADDR_BITS-1:0] DPRA;
    logic [WIDTH-1:0]     SPO;
    logic [WIDTH-1:0]     DPO;
    logic                 BUSY;
    logic                 WR_DROP;
    logic                 dbg_state;   // 0 = CLEAR sweep, 1 = READY

    modport master (
        output WE, A, D, DPRA,
        input  SPO, DPO, BUSY, WR_DROP, dbg_state
    );

    modport slave (
        input  WE, A, D, DPRA,
        output SPO, DPO, BUSY, WR_DROP, dbg_state
    );
endinterface

// File: rtl/ram_dp_param.sv
// Parametrised dual-port distributed RAM with a post-reset clear sweep and an optional
// registered dual-port read. All sequential logic runs on the WCLK edge picked by CLK_INV.
module ram_dp_param #(
    parameter int                 WIDTH     = 8,
    parameter int                 ADDR_BITS = 6,
    parameter logic [WIDTH-1:0]   CLEAR_VAL = '0,
    parameter int                 READ_REG  = 0,
    parameter int                 CLK_INV   = 0
) (
    input  logic               WCLK,
    input  logic               RST_N,
    ram_dp_param_if.slave      bus
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] PTR_LAST = (ADDR_BITS + 1)'(DEPTH - 1);
    localparam logic [ADDR_BITS:0] PTR_ONE  = (ADDR_BITS + 1)'(1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    logic clk_int;

    generate
        if (CLK_INV != 0) begin : g_clk_fall
            assign clk_int = ~WCLK;
        end else begin : g_clk_rise
            assign clk_int = WCLK;
        end
    endgenerate

    state_t               state_q, state_d;
    logic [ADDR_BITS:0]   ptr_q, ptr_d;
    logic                 wr_drop_q, wr_drop_d;
    logic                 busy;

    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_wa;
    logic [WIDTH-1:0]     mem_wd;
    logic [WIDTH-1:0]     mem_q [DEPTH];

    logic [WIDTH-1:0]     spo_raw;
    logic [WIDTH-1:0]     dpo_raw;
    logic [WIDTH-1:0]     dpo_sel;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_drop_d = wr_drop_q;
        mem_we    = 1'b0;
        mem_wa    = bus.A;
        mem_wd    = bus.D;
        case (state_q)
            ST_CLEAR: begin
                // The sweep owns the write port; a user write here is discarded and flagged.
                mem_we = 1'b1;
                mem_wa = ptr_q[ADDR_BITS-1:0];
                mem_wd = CLEAR_VAL;
                ptr_d  = ptr_q + PTR_ONE;
                if (bus.WE) begin
                    wr_drop_d = 1'b1;
                end
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                mem_we = bus.WE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk_int or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_CLEAR;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_ff @(posedge clk_int) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign busy    = (state_q == ST_CLEAR);
    assign spo_raw = mem_q[bus.A];
    assign dpo_raw = mem_q[bus.DPRA];

    generate
        if (READ_REG != 0) begin : g_dpo_reg
            logic [WIDTH-1:0] dpo_q, dpo_d;

            // Loading CLEAR_VAL during the sweep keeps the first READY read free of stale data.
            always_comb begin
                dpo_d = busy ? CLEAR_VAL : dpo_raw;
            end

            always_ff @(posedge clk_int or negedge RST_N) begin
                if (!RST_N) begin
                    dpo_q <= CLEAR_VAL;
                end else begin
                    dpo_q <= dpo_d;
                end
            end

            assign dpo_sel = dpo_q;
        end else begin : g_dpo_comb
            assign dpo_sel = dpo_raw;
        end
    endgenerate

    assign bus.SPO       = busy ? CLEAR_VAL : spo_raw;
    assign bus.DPO       = busy ? CLEAR_VAL : dpo_sel;
    assign bus.BUSY      = busy;
    assign bus.WR_DROP   = wr_drop_q;
    assign bus.dbg_state = state_q;
endmodule
